button_pulse_gen: RTL and testbench
===================================

# button_pulse_gen

Conditions a raw push-button into a clean single-cycle `button` strobe for the memory write/read sequencer that follows it. It sits directly upstream of that sequencer on `clk_g`: it synchronises the asynchronous pad input, debounces it with a stable-time counter, and emits exactly one pulse per accepted press. It also exposes the debounced level and a running press count for LED/debug use.

## Interface
- `DEBOUNCE_CYCLES`, default 32'd1_000_000: consecutive stable cycles needed to accept a press or a release; must be ≥ 1.
- `REPEAT_DELAY`, default 32'd50_000_000: hold cycles in PRESSED before the first auto-repeat pulse. Used only with `BTN_REPEAT_EN`; must be ≥ 1.
- `REPEAT_PERIOD`, default 32'd10_000_000: cycles between later auto-repeat pulses. Used only with `BTN_REPEAT_EN`; must be ≥ 1.
- `clk_g`  in  1: the single system clock. All logic updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `btn_raw`  in  1: raw, bouncing, asynchronous button pad; active-high.
- `button`  out  1: one-cycle strobe per accepted press (and per repeat); registered.
- `btn_level`  out  1: debounced button level; registered.
- `press_cnt`  out  8: count of emitted `button` pulses; wraps from 255 to 0.

## Operation
- **Synchroniser.** Two flops: `btn_raw` → `s1` → `s2`. The FSM reads only `s2`.
- **States:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. A 32-bit counter `cnt` is shared by all states.
- **IDLE:**
  - If `s2`=1, go to PRESS_WAIT with `cnt`=0.
  - Otherwise stay.
- **PRESS_WAIT:**
  - If `s2`=0, return to IDLE. This is a glitch: no pulse, no count.
  - Otherwise `cnt`++.
  - When `cnt`==DEBOUNCE_CYCLES-1 and `s2`=1, go to PRESSED with `cnt`=0, `button`=1 for that one cycle, and `press_cnt`++.
- **PRESSED:**
  - If `s2`=0, go to RELEASE_WAIT with `cnt`=0.
  - Otherwise, with `BTN_REPEAT_EN`, `cnt`++ (see Configuration).
- **RELEASE_WAIT:**
  - If `s2`=1, go back to PRESSED with `cnt`=0. This is a release bounce: no new pulse.
  - Otherwise `cnt`++.
  - When `cnt`==DEBOUNCE_CYCLES-1, go to IDLE.
- **Debounced level.** `btn_level`=1 exactly when the registered state is PRESSED or RELEASE_WAIT.
- **Pulse width.** `button` is never high for two consecutive cycles.
- **Counter width.** `press_cnt` is 8-bit modulo arithmetic; `cnt` is 32-bit and never wraps, because it is bounded by the parameters.

## Timing
- **Reset.** While `rst_n`=0 at a rising edge:
  - State becomes IDLE.
  - `s1`, `s2`, `cnt`, `button`, `btn_level` and `press_cnt` all become 0.
- **Reset during a press.** The press is abandoned. If the button is still held after reset, it is debounced afresh and produces a new pulse.
- **Press latency.** Let E be the first edge that samples `btn_raw`=1, with the input stable from then on. `button` goes high after edge E+DEBOUNCE_CYCLES+2 and is low again after the next edge.
- **Level timing.** `btn_level` rises on the same edge that `button` rises.
- **Release latency.** `btn_level` falls DEBOUNCE_CYCLES+2 edges after the first sampled 0, provided the input stays low.
- **Simultaneous events.** A debounce completion and a bounce on the same edge resolve by `s2`: the transition happens only if `s2` still holds the awaited value.

## Configuration
- **Macro:** `BTN_REPEAT_EN`.
- **Defined:** in PRESSED with `s2`=1, `cnt` increments.
  - When `cnt`==REPEAT_DELAY-1, emit a `button` pulse, increment `press_cnt`, and set `cnt` to REPEAT_DELAY-REPEAT_PERIOD. Result: repeats every REPEAT_PERIOD cycles.
  - REPEAT_PERIOD must be ≤ REPEAT_DELAY.
  - Releasing the button stops repeats at once.
- **Not defined:** PRESSED holds `cnt` at 0. There is exactly one pulse per press regardless of hold time, and the repeat parameters are ignored.

## Structure
- **Shared package/header (`lab_defs`):**
  - The four state encodings (2-bit localparams).
  - The default DEBOUNCE/REPEAT constants, so the sequencer and top level share them.
- **Sub-module `sync_2ff`:** 1-bit two-flop synchroniser with `clk_g`/`rst_n`. It is reused for other pad inputs.
- **Top module:** the FSM, `cnt` and the output registers stay in `button_pulse_gen`.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- **Clean press.** Hold `rst_n`=0 for 2 edges, then `btn_raw`=1 from edge E → `button` high only after edge E+6; `btn_level`=1 from then on; `press_cnt`=1.
- **Glitch rejection.** `btn_raw`=1 for 3 cycles, then 0 → no `button` pulse, `btn_level` stays 0, `press_cnt` stays 0.
- **Bouncy release.** While pressed, `btn_raw` goes 0,1,0 (1 cycle each) then stays 0 → no extra pulse; `btn_level` falls 6 edges after the last 1→0 sample; `press_cnt` unchanged.
- **Counter wrap.** 256 clean presses → `press_cnt` reads 0 with 256 single-cycle pulses observed.
- **Reset mid-press.** Assert `rst_n`=0 for 1 edge while in PRESSED with the button held → all outputs 0; after release of reset, one new pulse after 6 edges.
- **Auto-repeat (`BTN_REPEAT_EN` only).** Hold for 20 cycles after the first pulse → pulses at +8, +11, +14, +17 after entering PRESSED; `press_cnt`=5. Without the macro: `press_cnt`=1.

Source files
------------

// File: rtl/lab_defs.sv
// Shared definitions for the button front end and the memory sequencer:
// FSM state encodings and default timing constants.
package lab_defs;

   localparam logic [1:0] IDLE_ENC         = 2'd0;
   localparam logic [1:0] PRESS_WAIT_ENC   = 2'd1;
   localparam logic [1:0] PRESSED_ENC      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT_ENC = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE         = IDLE_ENC,
      ST_PRESS_WAIT   = PRESS_WAIT_ENC,
      ST_PRESSED      = PRESSED_ENC,
      ST_RELEASE_WAIT = RELEASE_WAIT_ENC
   } btn_state_t;

   localparam logic [31:0] DEF_DEBOUNCE_CYCLES = 32'd1_000_000;
   localparam logic [31:0] DEF_REPEAT_DELAY    = 32'd50_000_000;
   localparam logic [31:0] DEF_REPEAT_PERIOD   = 32'd10_000_000;

endpackage

// File: rtl/button_pulse_gen_if.sv
// Button front-end signal bundle: raw pad in, strobe/level/count out.
interface button_pulse_gen_if;

   logic       btn_raw;
   logic       button;
   logic       btn_level;
   logic [7:0] press_cnt;

   modport master (output btn_raw, input button, input btn_level, input press_cnt);
   modport slave  (input btn_raw, output button, output btn_level, output press_cnt);

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous pad inputs.
module sync_2ff (
   input  logic clk_g,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1_r;
   logic s2_r;

   // two-stage metastability filter, cleared by synchronous reset
   always_ff @(posedge clk_g) begin
      if (!rst_n) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= d;
         s2_r <= s1_r;
      end
   end

   assign q = s2_r;

endmodule

// File: rtl/button_pulse_gen.sv
// Push-button conditioner: synchronise, debounce, one strobe per press.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module button_pulse_gen
   import lab_defs::*;
#(
   parameter logic [31:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [31:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter logic [31:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic              clk_g,
   input  logic              rst_n,
   button_pulse_gen_if.slave bus
);

   btn_state_t  state_r;
   logic [31:0] cnt_r;
   logic        button_r;
   logic        level_r;
   logic [7:0]  press_cnt_r;
   logic        s2_s;

   sync_2ff u_sync (
      .clk_g (clk_g),
      .rst_n (rst_n),
      .d     (bus.btn_raw),
      .q     (s2_s)
   );

`ifndef BTN_REPEAT_EN
   logic unused_repeat_cfg_s;
   assign unused_repeat_cfg_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

   // debounce FSM; level is registered from the next state so it tracks state_r
   always_ff @(posedge clk_g) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 32'd0;
         button_r    <= 1'b0;
         level_r     <= 1'b0;
         press_cnt_r <= 8'd0;
      end else begin
         button_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               level_r <= 1'b0;
               cnt_r   <= 32'd0;
               if (s2_s) begin
                  state_r <= ST_PRESS_WAIT;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_PRESS_WAIT: begin
               if (!s2_s) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 32'd0;
                  level_r <= 1'b0;
               end else if (cnt_r == DEBOUNCE_CYCLES - 32'd1) begin
                  state_r     <= ST_PRESSED;
                  cnt_r       <= 32'd0;
                  level_r     <= 1'b1;
                  button_r    <= 1'b1;
                  press_cnt_r <= press_cnt_r + 8'd1;
               end else begin
                  state_r <= ST_PRESS_WAIT;
                  cnt_r   <= cnt_r + 32'd1;
                  level_r <= 1'b0;
               end
            end
            ST_PRESSED: begin
               level_r <= 1'b1;
               if (!s2_s) begin
                  state_r <= ST_RELEASE_WAIT;
                  cnt_r   <= 32'd0;
               end else begin
                  state_r <= ST_PRESSED;
`ifdef BTN_REPEAT_EN
                  // reload keeps later repeats REPEAT_PERIOD apart
                  if (cnt_r == REPEAT_DELAY - 32'd1) begin
                     cnt_r       <= REPEAT_DELAY - REPEAT_PERIOD;
                     button_r    <= 1'b1;
                     press_cnt_r <= press_cnt_r + 8'd1;
                  end else begin
                     cnt_r <= cnt_r + 32'd1;
                  end
`else
                  cnt_r <= 32'd0;
`endif
               end
            end
            ST_RELEASE_WAIT: begin
               if (s2_s) begin
                  state_r <= ST_PRESSED;
                  cnt_r   <= 32'd0;
                  level_r <= 1'b1;
               end else if (cnt_r == DEBOUNCE_CYCLES - 32'd1) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 32'd0;
                  level_r <= 1'b0;
               end else begin
                  state_r <= ST_RELEASE_WAIT;
                  cnt_r   <= cnt_r + 32'd1;
                  level_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 32'd0;
               level_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.button    = button_r;
   assign bus.btn_level = level_r;
   assign bus.press_cnt = press_cnt_r;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboarded bench for button_pulse_gen with DEBOUNCE=4, DELAY=8, PERIOD=3.
module tb_button_pulse_gen;

   localparam logic [31:0] DB = 32'd4;
   localparam logic [31:0] RD = 32'd8;
   localparam logic [31:0] RP = 32'd3;

   logic clk_g = 1'b0;
   logic rst_n = 1'b0;

   button_pulse_gen_if bus ();

   button_pulse_gen #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk_g (clk_g),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk_g = ~clk_g;

   int cyc = 0;
   always @(posedge clk_g) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic [7:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   pulses = 0;
   logic prev_button = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push(input int at, input logic [7:0] c);
      exp_t t;
      t.at  = at;
      t.cnt = c;
      q.push_back(t);
   endfunction

   // monitor: every observed strobe must match the next scoreboard entry
   always @(negedge clk_g) begin
      if (bus.button) begin
         pulses++;
         chk("pulse_width", int'(prev_button), 0);
         if (q.size() == 0) begin
            chk("unexpected_pulse", cyc, -1);
         end else begin
            mon_e = q.pop_front();
            chk("pulse_cycle", cyc, mon_e.at);
            chk("pulse_count", int'(bus.press_cnt), int'(mon_e.cnt));
         end
      end
      prev_button = bus.button;
   end

   task automatic press(input int hold);
      bus.btn_raw = 1'b1;
      repeat (7 + hold) @(negedge clk_g);
   endtask

   task automatic release_btn();
      bus.btn_raw = 1'b0;
      repeat (10) @(negedge clk_g);
   endtask

   initial begin
      int e;
      int f;
      int p;
      int r;
      int start;
      logic [7:0] exp_final;

      bus.btn_raw = 1'b0;
      rst_n       = 1'b0;
      repeat (2) @(negedge clk_g);
      chk("reset_button", int'(bus.button), 0);
      chk("reset_level", int'(bus.btn_level), 0);
      chk("reset_cnt", int'(bus.press_cnt), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_g);

      // clean press with exact level edges
      bus.btn_raw = 1'b1;
      e = cyc + 1;
      push(e + 6, 8'd1);
      repeat (6) @(negedge clk_g);
      chk("clean_level_before", int'(bus.btn_level), 0);
      @(negedge clk_g);
      chk("clean_level_rise", int'(bus.btn_level), 1);
      chk("clean_cnt", int'(bus.press_cnt), 1);
      repeat (3) @(negedge clk_g);
      bus.btn_raw = 1'b0;
      f = cyc + 1;
      repeat (6) @(negedge clk_g);
      chk("clean_level_hold", int'(bus.btn_level), 1);
      @(negedge clk_g);
      chk("clean_level_fall", int'(bus.btn_level), 0);
      repeat (4) @(negedge clk_g);
      chk("clean_release_at", cyc, f + 10);

      // glitch shorter than the debounce window
      bus.btn_raw = 1'b1;
      repeat (3) @(negedge clk_g);
      bus.btn_raw = 1'b0;
      repeat (12) @(negedge clk_g);
      chk("glitch_level", int'(bus.btn_level), 0);
      chk("glitch_cnt", int'(bus.press_cnt), 1);

      // bouncy release: 0,1,0 then low
      push(cyc + 7, 8'd2);
      press(3);
      bus.btn_raw = 1'b0;
      @(negedge clk_g);
      bus.btn_raw = 1'b1;
      @(negedge clk_g);
      bus.btn_raw = 1'b0;
      f = cyc + 1;
      repeat (6) @(negedge clk_g);
      chk("bounce_level_hold", int'(bus.btn_level), 1);
      @(negedge clk_g);
      chk("bounce_level_fall", int'(bus.btn_level), 0);
      chk("bounce_cnt", int'(bus.press_cnt), 2);
      repeat (3) @(negedge clk_g);

      // long hold: repeats only when the feature is built in
      p = cyc + 7;
      push(p, 8'd3);
`ifdef BTN_REPEAT_EN
      push(p + 8, 8'd4);
      push(p + 11, 8'd5);
      push(p + 14, 8'd6);
      push(p + 17, 8'd7);
      exp_final = 8'd7;
`else
      exp_final = 8'd3;
`endif
      press(17);
      release_btn();
      chk("hold_cnt", int'(bus.press_cnt), int'(exp_final));

      // reset while held in PRESSED
      push(cyc + 7, exp_final + 8'd1);
      press(3);
      rst_n = 1'b0;
      @(negedge clk_g);
      chk("midrst_button", int'(bus.button), 0);
      chk("midrst_level", int'(bus.btn_level), 0);
      chk("midrst_cnt", int'(bus.press_cnt), 0);
      rst_n = 1'b1;
      r = cyc;
      push(r + 7, 8'd1);
      repeat (9) @(negedge clk_g);
      release_btn();
      chk("midrst_after_cnt", int'(bus.press_cnt), 1);

      // 256 presses from a fresh reset wrap the counter to zero
      rst_n = 1'b0;
      @(negedge clk_g);
      rst_n = 1'b1;
      start = pulses;
      for (int i = 0; i < 256; i++) begin
         push(cyc + 7, 8'(i + 1));
         press(1);
         release_btn();
      end
      chk("wrap_cnt", int'(bus.press_cnt), 0);
      chk("wrap_pulses", pulses - start, 256);

      repeat (2) @(negedge clk_g);
      chk("pending_expected", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
